// File: rtl/sap_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sap_mem_arbiter_if
// Description : Requester handshakes and RAM strobe bundle for sap_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sap_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              prog_mode;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_ack;
    logic [DATA_W-1:0] ldr_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              busy;
    logic              owner_ldr;

    // Arbiter side of the bundle
    modport slave (
        input  prog_mode,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_ack, ldr_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output busy, owner_ldr
    );

    // Requesters plus RAM side of the bundle
    modport master (
        output prog_mode,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_ack, ldr_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  busy, owner_ldr
    );
endinterface
`default_nettype wire

// File: rtl/sap_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sap_mem_arbiter
// Description : Round-robin arbiter sharing the SAP program/data RAM between
//               the CPU and the front-panel program loader.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input wire            clock,
    input wire            reset,
    sap_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_owner_ldr;
    logic              r_rr_last_ldr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_ldr_rdata;

    logic              w_cpu_elig;
    logic              w_ldr_elig;
    logic              w_grant;
    logic              w_grant_ldr;
    logic              w_access;
    logic              w_resp;
    logic              w_cpu_ack;
    logic              w_ldr_ack;

    assign w_cpu_elig = bus.cpu_req & ~bus.prog_mode;
    assign w_ldr_elig = bus.ldr_req;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decision; in RESP only the other requester may
    // chain straight into a new access.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_ldr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cpu_elig || w_ldr_elig) begin
                    w_grant      = 1'b1;
                    w_grant_ldr  = w_ldr_elig && (!w_cpu_elig || !r_rr_last_ldr);
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                if (r_owner_ldr ? w_cpu_elig : w_ldr_elig) begin
                    w_grant      = 1'b1;
                    w_grant_ldr  = ~r_owner_ldr;
                    w_next_state = ST_ACCESS;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Access capture, round-robin pointer and read-data holding registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_owner_ldr   <= 1'b0;
            r_rr_last_ldr <= 1'b1;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_cpu_rdata   <= '0;
            r_ldr_rdata   <= '0;
        end else begin
            if (w_resp) begin
                r_rr_last_ldr <= r_owner_ldr;
                if (!r_we) begin
                    if (r_owner_ldr) begin
                        r_ldr_rdata <= bus.ram_rdata;
                    end else begin
                        r_cpu_rdata <= bus.ram_rdata;
                    end
                end
            end
            if (w_grant) begin
                r_owner_ldr <= w_grant_ldr;
                r_we        <= w_grant_ldr ? bus.ldr_we    : bus.cpu_we;
                r_addr      <= w_grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
                r_wdata     <= w_grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
            end
        end
    end

    assign w_access  = (r_state == ST_ACCESS);
    assign w_resp    = (r_state == ST_RESP);
    assign w_cpu_ack = w_resp & ~r_owner_ldr;
    assign w_ldr_ack = w_resp &  r_owner_ldr;

    assign bus.ram_en    = w_access;
    assign bus.ram_we    = w_access & r_we;
    assign bus.ram_addr  = r_addr;
    assign bus.ram_wdata = r_wdata;

    assign bus.cpu_ack   = w_cpu_ack;
    assign bus.ldr_ack   = w_ldr_ack;
    assign bus.cpu_stall = bus.cpu_req & ~w_cpu_ack;

    // RAM data arrives in the RESP cycle, so read data bypasses the holding
    // register to be valid together with the ack.
    assign bus.cpu_rdata = (w_cpu_ack && !r_we) ? bus.ram_rdata : r_cpu_rdata;
    assign bus.ldr_rdata = (w_ldr_ack && !r_we) ? bus.ram_rdata : r_ldr_rdata;

    assign bus.busy      = ~(r_state == ST_IDLE);
    assign bus.owner_ldr = r_owner_ldr;

endmodule
`default_nettype wire
